// File: rtl/rf_rename_mp.sv
// rf_rename_mp: architectural register file with rename-tag table.
//   Sits between decode (rename writes, operand reads), ROB (commit writes)
//   and IF (jalr base read). Tag value all-ones (NONE) means "value ready".
//   Optional snapshot table enabled by macro RF_CHECKPOINT_EN.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   need_flush_in                       : clear all tags, keep values
//   rob_valid/rob_rd/rob_value/rob_tag  : commit write
//   dec_valid/dec_rd/dec_tag            : rename write
//   dec_rs -> value_out/tag_out         : NUM_RD combinational read ports with commit bypass
//   if_rs_jalr -> value_jalr_out        : unbypassed jalr base read
//   pending_cnt                         : registered count of renamed registers
//   ckpt_save_in/ckpt_restore_in        : only with RF_CHECKPOINT_EN
module rf_rename_mp #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_NUM        = 32,
  parameter int unsigned REG_NUM_WIDTH  = 5,
  parameter int unsigned ROB_SIZE_WIDTH = 4,
  parameter int unsigned NUM_RD         = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
`ifdef RF_CHECKPOINT_EN
  input  logic                               ckpt_save_in,
  input  logic                               ckpt_restore_in,
`endif
  input  logic                               rdy_in,
  input  logic                               need_flush_in,
  input  logic                               rob_valid,
  input  logic [REG_NUM_WIDTH-1:0]           rob_rd,
  input  logic [XLEN-1:0]                    rob_value,
  input  logic [ROB_SIZE_WIDTH-1:0]          rob_tag,
  input  logic                               dec_valid,
  input  logic [REG_NUM_WIDTH-1:0]           dec_rd,
  input  logic [ROB_SIZE_WIDTH-1:0]          dec_tag,
  input  logic [NUM_RD*REG_NUM_WIDTH-1:0]    dec_rs,
  output logic [NUM_RD*XLEN-1:0]             value_out,
  output logic [NUM_RD*ROB_SIZE_WIDTH-1:0]   tag_out,
  input  logic [REG_NUM_WIDTH-1:0]           if_rs_jalr,
  output logic [XLEN-1:0]                    value_jalr_out,
  output logic [REG_NUM_WIDTH:0]             pending_cnt
);

  localparam int unsigned CNT_W = REG_NUM_WIDTH + 1;
  localparam logic [ROB_SIZE_WIDTH-1:0] NONE = '1;

  logic [XLEN-1:0]           r_regs [REG_NUM];
  logic [ROB_SIZE_WIDTH-1:0] r_tags [REG_NUM];
  logic [CNT_W-1:0]          r_cnt;

  logic [ROB_SIZE_WIDTH-1:0] w_tags_upd [REG_NUM];
  logic [ROB_SIZE_WIDTH-1:0] w_tags_nxt [REG_NUM];
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_commit;
  logic                      w_rename;

`ifdef RF_CHECKPOINT_EN
  logic [ROB_SIZE_WIDTH-1:0] r_snap     [REG_NUM];
  logic [ROB_SIZE_WIDTH-1:0] w_snap_clr [REG_NUM];
  logic [ROB_SIZE_WIDTH-1:0] w_snap_nxt [REG_NUM];
`endif

  // x0 is never written nor renamed
  assign w_commit = rob_valid && (rob_rd != '0);
  assign w_rename = dec_valid && (dec_rd != '0);

  // Next tag state: commit clear, then rename overrides; flush/restore replace it
  always_comb begin
    for (int i = 0; i < int'(REG_NUM); i++) begin
      w_tags_upd[i] = r_tags[i];
      w_tags_nxt[i] = NONE;
`ifdef RF_CHECKPOINT_EN
      w_snap_clr[i] = r_snap[i];
      w_snap_nxt[i] = NONE;
`endif
      if (i != 0) begin
        if (w_commit && (rob_rd == REG_NUM_WIDTH'(i)) && (r_tags[i] == rob_tag))
          w_tags_upd[i] = NONE;
        if (w_rename && (dec_rd == REG_NUM_WIDTH'(i)))
          w_tags_upd[i] = dec_tag;
`ifdef RF_CHECKPOINT_EN
        if (w_commit && (rob_rd == REG_NUM_WIDTH'(i)) && (r_snap[i] == rob_tag))
          w_snap_clr[i] = NONE;
        // Save captures this edge's post-update tags; flush/restore take precedence
        if (!need_flush_in && !ckpt_restore_in && ckpt_save_in)
          w_snap_nxt[i] = w_tags_upd[i];
        else
          w_snap_nxt[i] = w_snap_clr[i];
        if (need_flush_in)
          w_tags_nxt[i] = NONE;
        else if (ckpt_restore_in)
          w_tags_nxt[i] = w_snap_clr[i];
        else
          w_tags_nxt[i] = w_tags_upd[i];
`else
        if (need_flush_in)
          w_tags_nxt[i] = NONE;
        else
          w_tags_nxt[i] = w_tags_upd[i];
`endif
      end
    end
  end

  // Pending count of the post-edge tag table
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < int'(REG_NUM); i++) begin
      if (w_tags_nxt[i] != NONE)
        w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
    end
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        r_regs[i] <= '0;
        r_tags[i] <= NONE;
`ifdef RF_CHECKPOINT_EN
        r_snap[i] <= NONE;
`endif
      end
      r_cnt <= '0;
    end else if (rdy_in) begin
      // Commit value is architectural: written even on a flush edge
      if (w_commit)
        r_regs[rob_rd] <= rob_value;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        r_tags[i] <= w_tags_nxt[i];
`ifdef RF_CHECKPOINT_EN
        r_snap[i] <= w_snap_nxt[i];
`endif
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Operand read ports with same-cycle commit bypass; x0 reads as 0/NONE
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [REG_NUM_WIDTH-1:0] w_rs;
    logic                     w_byp;
    assign w_rs  = dec_rs[k*REG_NUM_WIDTH +: REG_NUM_WIDTH];
    assign w_byp = rob_valid && (rob_rd == w_rs);
    assign value_out[k*XLEN +: XLEN] =
      (w_rs == '0) ? '0 : (w_byp ? rob_value : r_regs[w_rs]);
    assign tag_out[k*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH] =
      ((w_rs == '0) || (w_byp && (rob_tag == r_tags[w_rs]))) ? NONE : r_tags[w_rs];
  end

  assign value_jalr_out = r_regs[if_rs_jalr];
  assign pending_cnt    = r_cnt;

endmodule

// File: tb/tb_rf_rename_mp.sv
// Bench for rf_rename_mp: directed vector table, hand sequences for reset,
// checkpoint and randomized traffic against a behavioural model.
module tb_rf_rename_mp;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 4;
  localparam int NR   = 2;
  localparam int NREG = 32;
  localparam logic [TW-1:0] NONE = 4'hF;

  logic              clk_in, rst_in, rdy_in, need_flush_in;
  logic              rob_valid, dec_valid;
  logic [RW-1:0]     rob_rd, dec_rd, if_rs_jalr;
  logic [XLEN-1:0]   rob_value;
  logic [TW-1:0]     rob_tag, dec_tag;
  logic [NR*RW-1:0]  dec_rs;
  logic [NR*XLEN-1:0] value_out;
  logic [NR*TW-1:0]  tag_out;
  logic [XLEN-1:0]   value_jalr_out;
  logic [RW:0]       pending_cnt;
`ifdef RF_CHECKPOINT_EN
  logic              ckpt_save_in, ckpt_restore_in;
`endif

  rf_rename_mp dut (
    .clk_in(clk_in), .rst_in(rst_in),
`ifdef RF_CHECKPOINT_EN
    .ckpt_save_in(ckpt_save_in), .ckpt_restore_in(ckpt_restore_in),
`endif
    .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .rob_valid(rob_valid), .rob_rd(rob_rd), .rob_value(rob_value), .rob_tag(rob_tag),
    .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_tag(dec_tag), .dec_rs(dec_rs),
    .value_out(value_out), .tag_out(tag_out),
    .if_rs_jalr(if_rs_jalr), .value_jalr_out(value_jalr_out),
    .pending_cnt(pending_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Behavioural model: plain arrays of values and outstanding tags
  logic [XLEN-1:0] m_regs [NREG];
  logic [TW-1:0]   m_tags [NREG];

  typedef struct {
    logic rdy; logic fl; logic cv; logic [RW-1:0] crd; logic [XLEN-1:0] cval; logic [TW-1:0] ctag;
    logic dv; logic [RW-1:0] drd; logic [TW-1:0] dtag; logic [RW-1:0] rs0; logic [RW-1:0] rs1;
    logic [XLEN-1:0] ev0; logic [TW-1:0] et0; logic [XLEN-1:0] ev1; logic [TW-1:0] et1; int ecnt;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_tags[i] = NONE;
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 1; i < NREG; i++) if (m_tags[i] != NONE) c++;
    return c;
  endfunction

  function automatic logic [XLEN-1:0] model_val(input logic [RW-1:0] r);
    if (r == 0) return '0;
    if (rob_valid && rob_rd == r) return rob_value;
    return m_regs[r];
  endfunction

  function automatic logic [TW-1:0] model_tag(input logic [RW-1:0] r);
    if (r == 0) return NONE;
    if (rob_valid && rob_rd == r && rob_tag == m_tags[r]) return NONE;
    return m_tags[r];
  endfunction

  // Apply the architectural rules of one clock edge to the model
  task automatic model_edge();
    logic match;
    if (!rdy_in) return;
    match = (m_tags[rob_rd] == rob_tag);
    if (rob_valid && rob_rd != 0) m_regs[rob_rd] = rob_value;
    if (need_flush_in) begin
      for (int i = 0; i < NREG; i++) m_tags[i] = NONE;
    end else begin
      if (rob_valid && rob_rd != 0 && match) m_tags[rob_rd] = NONE;
      if (dec_valid && dec_rd != 0) m_tags[dec_rd] = dec_tag;
    end
  endtask

  task automatic drive(input logic rdy, input logic fl, input logic cv, input int crd,
                       input logic [XLEN-1:0] cval, input int ctag, input logic dv,
                       input int drd, input int dtag, input int rs0, input int rs1, input int jr);
    rdy_in = rdy; need_flush_in = fl;
    rob_valid = cv; rob_rd = RW'(crd); rob_value = cval; rob_tag = TW'(ctag);
    dec_valid = dv; dec_rd = RW'(drd); dec_tag = TW'(dtag);
    dec_rs = {RW'(rs1), RW'(rs0)};
    if_rs_jalr = RW'(jr);
`ifdef RF_CHECKPOINT_EN
    ckpt_save_in = 1'b0; ckpt_restore_in = 1'b0;
`endif
  endtask

  task automatic idle(input int rs0, input int rs1);
    drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 0, 1'b0, 0, 0, rs0, rs1, 0);
  endtask

  // Clock one edge, update model, check pending count (exp<0: from model)
  task automatic edge_step(input int exp_cnt);
    @(posedge clk_in);
    model_edge();
    #1;
    chk("pending_cnt", 32'(pending_cnt), (exp_cnt < 0) ? 32'(model_cnt()) : 32'(exp_cnt));
    @(negedge clk_in);
  endtask

  task automatic add_vec(input logic rdy, input logic fl, input logic cv, input int crd,
                         input logic [XLEN-1:0] cval, input int ctag, input logic dv,
                         input int drd, input int dtag, input int rs0, input int rs1,
                         input logic [XLEN-1:0] ev0, input int et0,
                         input logic [XLEN-1:0] ev1, input int et1, input int ecnt);
    vec_t v;
    v.rdy = rdy; v.fl = fl; v.cv = cv; v.crd = RW'(crd); v.cval = cval; v.ctag = TW'(ctag);
    v.dv = dv; v.drd = RW'(drd); v.dtag = TW'(dtag); v.rs0 = RW'(rs0); v.rs1 = RW'(rs1);
    v.ev0 = ev0; v.et0 = TW'(et0); v.ev1 = ev1; v.et1 = TW'(et1); v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic check_reads(input string tagname, input logic [XLEN-1:0] ev0, input logic [TW-1:0] et0,
                             input logic [XLEN-1:0] ev1, input logic [TW-1:0] et1);
    chk($sformatf("%s val0", tagname), value_out[0 +: XLEN], ev0);
    chk($sformatf("%s tag0", tagname), 32'(tag_out[0 +: TW]), 32'(et0));
    chk($sformatf("%s val1", tagname), value_out[XLEN +: XLEN], ev1);
    chk($sformatf("%s tag1", tagname), 32'(tag_out[TW +: TW]), 32'(et1));
  endtask

  initial begin
    int crd;
    int ctag;
    rst_in = 1'b1;
    idle(0, 0);
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    //       rdy   fl    cv    crd cval          ctag dv    drd dtag rs0 rs1 ev0           et0 ev1           et1 cnt
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b0, 0, 0,  5, 5, 32'h0,         15, 32'h0,         15, 0);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b1, 3, 2,  3, 0, 32'h0,         15, 32'h0,         15, 1);
    add_vec(1'b1, 1'b0, 1'b1, 3, 32'hDEADBEEF,  2,  1'b0, 0, 0,  3, 3, 32'hDEADBEEF,  15, 32'hDEADBEEF,  15, 0);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b0, 0, 0,  3, 5, 32'hDEADBEEF,  15, 32'h0,         15, 0);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b1, 3, 2,  3, 0, 32'hDEADBEEF,  15, 32'h0,         15, 1);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b1, 3, 5,  3, 0, 32'hDEADBEEF,  2,  32'h0,         15, 1);
    add_vec(1'b1, 1'b0, 1'b1, 3, 32'h11,        2,  1'b0, 0, 0,  3, 0, 32'h11,        5,  32'h0,         15, 1);
    add_vec(1'b1, 1'b0, 1'b1, 4, 32'h44,        1,  1'b1, 4, 6,  3, 4, 32'h11,        5,  32'h44,        15, 2);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b0, 0, 0,  4, 3, 32'h44,        6,  32'h11,        5,  2);
    add_vec(1'b1, 1'b0, 1'b1, 0, 32'h1234,      3,  1'b1, 0, 3,  0, 0, 32'h0,         15, 32'h0,         15, 2);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b0, 0, 0,  0, 4, 32'h0,         15, 32'h44,        6,  2);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b1, 1, 1,  1, 0, 32'h0,         15, 32'h0,         15, 3);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b1, 2, 7,  1, 2, 32'h0,         1,  32'h0,         15, 4);
    add_vec(1'b1, 1'b1, 1'b1, 2, 32'h7,         9,  1'b1, 5, 4,  2, 1, 32'h7,         7,  32'h0,         1,  0);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b0, 0, 0,  2, 3, 32'h7,         15, 32'h11,        15, 0);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b1, 1, 1,  1, 4, 32'h0,         15, 32'h44,        15, 1);
    add_vec(1'b0, 1'b1, 1'b1, 3, 32'h99,        0,  1'b1, 6, 2,  1, 6, 32'h0,         1,  32'h0,         15, 1);
    add_vec(1'b1, 1'b0, 1'b0, 0, 32'h0,         0,  1'b0, 0, 0,  1, 3, 32'h0,         1,  32'h11,        15, 1);

    foreach (vq[i]) begin
      drive(vq[i].rdy, vq[i].fl, vq[i].cv, int'(vq[i].crd), vq[i].cval, int'(vq[i].ctag),
            vq[i].dv, int'(vq[i].drd), int'(vq[i].dtag), int'(vq[i].rs0), int'(vq[i].rs1), 0);
      #2;
      check_reads($sformatf("vec%0d", i), vq[i].ev0, vq[i].et0, vq[i].ev1, vq[i].et1);
      edge_step(vq[i].ecnt);
    end

    // Asynchronous reset in the middle of a rename, no clock edge needed
    drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 0, 1'b1, 7, 3, 7, 3, 0);
    #2;
    edge_step(-1);
    idle(7, 3);
    #2;
    chk("pre-reset tag x7", 32'(tag_out[0 +: TW]), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 0, 1'b1, 7, 3, 7, 3, 0);
    rst_in = 1'b1;
    #1;
    chk("async rst tag x7", 32'(tag_out[0 +: TW]), 32'(NONE));
    chk("async rst val x3", value_out[XLEN +: XLEN], 32'h0);
    chk("async rst cnt", 32'(pending_cnt), 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(0, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      crd = int'($urandom_range(0, 7));
      ctag = ($urandom_range(0, 1) == 1 && m_tags[crd] != NONE) ? int'(m_tags[crd])
                                                                : int'($urandom_range(0, 14));
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
            crd, $urandom, ctag, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 14)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)));
      #2;
      check_reads($sformatf("rnd%0d", n), model_val(dec_rs[0 +: RW]), model_tag(dec_rs[0 +: RW]),
                  model_val(dec_rs[RW +: RW]), model_tag(dec_rs[RW +: RW]));
      chk($sformatf("rnd%0d jalr", n), value_jalr_out, m_regs[if_rs_jalr]);
      edge_step(-1);
    end

`ifdef RF_CHECKPOINT_EN
    // Save, rename, commit, restore: restored table reflects the commit
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    model_reset();
    idle(0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 0, 1'b1, 1, 1, 0, 0, 0);
    edge_step(1);
    idle(0, 0); ckpt_save_in = 1'b1;
    edge_step(1);
    drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 0, 1'b1, 2, 2, 0, 0, 0);
    edge_step(2);
    drive(1'b1, 1'b0, 1'b1, 1, 32'h5, 1, 1'b0, 0, 0, 0, 0, 0);
    edge_step(1);
    idle(0, 0); ckpt_restore_in = 1'b1;
    edge_step(0);
    idle(1, 2);
    #2;
    check_reads("ckpt", 32'h5, NONE, 32'h0, NONE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
